// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams bytes into instruction memory, then releases the CPU from reset.
// Optional checksum byte after the last write is enabled with `define IMEM_LOAD_CHECKSUM_EN.
module imem_boot_ctrl #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [7:0]  cpu_pc,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic [6:0]  word_cnt,
  output logic        err
);

  // state | meaning
  // IDLE  | after reset, waiting for boot_start
  // LOAD  | accepting program bytes into the assembly register
  // WRITE | one-cycle write of the assembled word
  // CHECK | accepting the checksum byte (checksum build only)
  // RUN   | CPU released, fetch address passed through
  // ERR   | overflow or checksum failure, waiting for boot_start
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WRITE, ST_CHECK, ST_RUN, ST_ERR
  } state_t;

  localparam logic [6:0] WordsMax = 7'(WORDS);

  state_t      state_q, state_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        last_q, last_d;
  logic        accept;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

`ifdef IMEM_LOAD_CHECKSUM_EN
  assign ld_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
`else
  assign ld_ready = (state_q == ST_LOAD);
`endif

  assign accept    = ld_valid && ld_ready;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = (state_q == ST_RUN) ? cpu_pc : {word_cnt_q[5:0], 2'b00};
  assign mem_wdata = asm_q;
  assign cpu_rst_n = (state_q == ST_RUN);
  assign word_cnt  = word_cnt_q;
  assign err       = (state_q == ST_ERR);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    last_d     = last_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (boot_start) begin
          state_d    = ST_LOAD;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
          last_d     = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // A byte arriving with the memory already full is an overflow; nothing is written.
          if (word_cnt_q == WordsMax) begin
            state_d = ST_ERR;
          end else begin
            asm_d[{byte_cnt_q, 3'b000} +: 8] = ld_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            last_d     = ld_last;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_d      = sum_q + ld_data;
`endif
            if ((byte_cnt_q == 2'd3) || ld_last) state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 7'd1;
        byte_cnt_d = '0;
        asm_d      = '0;
        if (last_q) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_RUN;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (ld_data == sum_q) ? ST_RUN : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      last_q     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      last_q     <= last_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl; a second instance with WORDS=2 exercises overflow.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic [7:0]  cpu_pc = '0;

  logic        ld_ready, mem_we, cpu_rst_n, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_cnt;

  logic        ld_ready_2, mem_we_2, cpu_rst_n_2, err_2;
  logic [7:0]  mem_addr_2;
  logic [31:0] mem_wdata_2;
  logic [6:0]  word_cnt_2;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  wr2_addr[$];
  logic [31:0] wr2_data[$];

  always #5 clk = ~clk;

  imem_boot_ctrl #(.WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .cpu_pc(cpu_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .word_cnt(word_cnt), .err(err)
  );

  imem_boot_ctrl #(.WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_2), .cpu_pc(cpu_pc),
    .mem_addr(mem_addr_2), .mem_we(mem_we_2), .mem_wdata(mem_wdata_2),
    .cpu_rst_n(cpu_rst_n_2), .word_cnt(word_cnt_2), .err(err_2)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (mem_we_2) begin
      wr2_addr.push_back(mem_addr_2);
      wr2_data.push_back(mem_wdata_2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr2_addr.delete();
    wr2_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic pulse_boot();
    boot_start = 1'b1;
    cyc();
    boot_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (!ld_ready && n < 20) begin
      cyc();
      n++;
    end
    vec_cnt++;
    if (ld_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL send_byte_ready: ld_ready=%b required 1 (byte %h)", ld_ready, d);
    end
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Checksum build: the controller sits in CHECK after the last write and needs the sum byte.
  task automatic finish_load(input logic [7:0] sum);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_byte(sum, 1'b0);
`else
    ld_data = sum;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    vec_cnt++;
    if ({ld_ready, mem_we, mem_wdata, mem_addr, cpu_rst_n, word_cnt, err} !== '0) begin
      err_cnt++;
      $display("FAIL %s: rdy=%b we=%b wdata=%h addr=%h cpu_rst_n=%b wcnt=%0d err=%b required all zero",
               tag, ld_ready, mem_we, mem_wdata, mem_addr, cpu_rst_n, word_cnt, err);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_state");
    vec_cnt++;
    if ({ld_ready_2, mem_we_2, cpu_rst_n_2, err_2, word_cnt_2} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state_2: rdy=%b we=%b cpu_rst_n=%b err=%b wcnt=%0d required zero",
               ld_ready_2, mem_we_2, cpu_rst_n_2, err_2, word_cnt_2);
    end
  endtask

  task automatic test_single_word();
    clear_log();
    pulse_boot();
    vec_cnt++;
    if (ld_ready !== 1'b1 || word_cnt !== 7'd0) begin
      err_cnt++;
      $display("FAIL single_load_entry: rdy=%b wcnt=%0d required 1/0", ld_ready, word_cnt);
    end
    send_byte(8'h13, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b1);
    vec_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h00A00313) begin
      err_cnt++;
      $display("FAIL single_write_cycle: we=%b addr=%h wdata=%h required 1/00/00A00313",
               mem_we, mem_addr, mem_wdata);
    end
    cyc();
    finish_load(8'hB6);
    vec_cnt++;
    if (cpu_rst_n !== 1'b1 || mem_we !== 1'b0 || word_cnt !== 7'd1) begin
      err_cnt++;
      $display("FAIL single_run: cpu_rst_n=%b we=%b wcnt=%0d required 1/0/1", cpu_rst_n, mem_we, word_cnt);
    end
    vec_cnt++;
    if (wr_data.size() != 1) begin
      err_cnt++;
      $display("FAIL single_write_count: %0d writes required 1", wr_data.size());
    end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00A00313) begin
      err_cnt++;
      $display("FAIL single_write_log: addr=%h data=%h required 00/00A00313", wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_partial_word();
    clear_log();
    pulse_boot();
    vec_cnt++;
    if (cpu_rst_n !== 1'b0 || word_cnt !== 7'd0 || ld_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL restart_from_run: cpu_rst_n=%b wcnt=%0d rdy=%b required 0/0/1",
               cpu_rst_n, word_cnt, ld_ready);
    end
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    vec_cnt++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h04 || mem_wdata !== 32'h00000605) begin
      err_cnt++;
      $display("FAIL partial_write_cycle: we=%b addr=%h wdata=%h required 1/04/00000605",
               mem_we, mem_addr, mem_wdata);
    end
    cyc();
    finish_load(8'h15);
    vec_cnt++;
    if (wr_data.size() != 2) begin
      err_cnt++;
      $display("FAIL partial_write_count: %0d writes required 2", wr_data.size());
    end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h04030201 ||
                 wr_addr[1] !== 8'h04 || wr_data[1] !== 32'h00000605) begin
      err_cnt++;
      $display("FAIL partial_write_log: %h:%h %h:%h required 00:04030201 04:00000605",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    vec_cnt++;
    if (word_cnt !== 7'd2 || cpu_rst_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL partial_run: wcnt=%0d cpu_rst_n=%b required 2/1", word_cnt, cpu_rst_n);
    end
  endtask

  task automatic test_run_pc();
    pulse_boot();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    cyc();
    finish_load(8'hAA);
    cpu_pc = 8'd24;
    #1;
    vec_cnt++;
    if (mem_addr !== 8'd24 || mem_we !== 1'b0 || cpu_rst_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL run_pc_24: addr=%0d we=%b cpu_rst_n=%b required 24/0/1", mem_addr, mem_we, cpu_rst_n);
    end
    cpu_pc = 8'h80;
    #1;
    vec_cnt++;
    if (mem_addr !== 8'h80) begin
      err_cnt++;
      $display("FAIL run_pc_80: addr=%h required 80", mem_addr);
    end
    pulse_boot();
    vec_cnt++;
    if (cpu_rst_n !== 1'b0 || mem_addr !== 8'h00 || ld_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL run_reboot: cpu_rst_n=%b addr=%h rdy=%b required 0/00/1", cpu_rst_n, mem_addr, ld_ready);
    end
    cpu_pc = 8'h00;
  endtask

  task automatic test_ignore_boot();
    clear_log();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    pulse_boot();
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    cyc();
    finish_load(8'h0A);
    vec_cnt++;
    if (wr_data.size() != 1) begin
      err_cnt++;
      $display("FAIL ignore_boot_count: %0d writes required 1", wr_data.size());
    end else if (wr_data[0] !== 32'h04030201 || wr_addr[0] !== 8'h00) begin
      err_cnt++;
      $display("FAIL ignore_boot_word: %h:%h required 00:04030201", wr_addr[0], wr_data[0]);
    end
    vec_cnt++;
    if (word_cnt !== 7'd1 || cpu_rst_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL ignore_boot_run: wcnt=%0d cpu_rst_n=%b required 1/1", word_cnt, cpu_rst_n);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clear_log();
    pulse_boot();
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 1'b0);
    vec_cnt++;
    if (err_2 !== 1'b1 || cpu_rst_n_2 !== 1'b0 || ld_ready_2 !== 1'b0 || word_cnt_2 !== 7'd2) begin
      err_cnt++;
      $display("FAIL overflow_err: err=%b cpu_rst_n=%b rdy=%b wcnt=%0d required 1/0/0/2",
               err_2, cpu_rst_n_2, ld_ready_2, word_cnt_2);
    end
    cyc();
    cyc();
    vec_cnt++;
    if (err_2 !== 1'b1 || mem_we_2 !== 1'b0) begin
      err_cnt++;
      $display("FAIL overflow_hold: err=%b we=%b required 1/0", err_2, mem_we_2);
    end
    vec_cnt++;
    if (wr2_data.size() != 2) begin
      err_cnt++;
      $display("FAIL overflow_write_count: %0d writes required 2", wr2_data.size());
    end else if (wr2_addr[0] !== 8'h00 || wr2_data[0] !== 32'h13121110 ||
                 wr2_addr[1] !== 8'h04 || wr2_data[1] !== 32'h17161514) begin
      err_cnt++;
      $display("FAIL overflow_write_log: %h:%h %h:%h required 00:13121110 04:17161514",
               wr2_addr[0], wr2_data[0], wr2_addr[1], wr2_data[1]);
    end
    pulse_boot();
    vec_cnt++;
    if (err_2 !== 1'b0 || ld_ready_2 !== 1'b1 || word_cnt_2 !== 7'd0) begin
      err_cnt++;
      $display("FAIL overflow_reboot: err=%b rdy=%b wcnt=%0d required 0/1/0", err_2, ld_ready_2, word_cnt_2);
    end
  endtask

  task automatic test_reset_midload();
    do_reset();
    clear_log();
    pulse_boot();
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    cpu_pc = 8'h5C;
    rst_n = 1'b0;
    cyc();
    check_reset_outputs("reset_midload");
    rst_n = 1'b1;
    cyc();
    cyc();
    vec_cnt++;
    if (wr_data.size() != 0 || ld_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_midload_idle: writes=%0d rdy=%b cpu_rst_n=%b required 0/0/0",
               wr_data.size(), ld_ready, cpu_rst_n);
    end
    cpu_pc = 8'h00;
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    pulse_boot();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
    cyc();
    vec_cnt++;
    if (ld_ready !== 1'b1 || cpu_rst_n !== 1'b0) begin
      err_cnt++;
      $display("FAIL check_state: rdy=%b cpu_rst_n=%b required 1/0", ld_ready, cpu_rst_n);
    end
    send_byte(8'h0A, 1'b0);
    vec_cnt++;
    if (cpu_rst_n !== 1'b1 || err !== 1'b0) begin
      err_cnt++;
      $display("FAIL checksum_good: cpu_rst_n=%b err=%b required 1/0", cpu_rst_n, err);
    end
    pulse_boot();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
    cyc();
    send_byte(8'h0B, 1'b0);
    vec_cnt++;
    if (cpu_rst_n !== 1'b0 || err !== 1'b1) begin
      err_cnt++;
      $display("FAIL checksum_bad: cpu_rst_n=%b err=%b required 0/1", cpu_rst_n, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_run_pc();
    test_ignore_boot();
    test_overflow();
    test_reset_midload();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter WORDS, default 64, instruction words loadable (1..64; byte address 8 bits wide).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port boot_start  input  1  one-cycle pulse requesting a (re)load.
REQ-005 SHALL have port ld_valid  input  1  loader byte valid.
REQ-006 SHALL have port ld_data  input  8  loader byte; little-endian within a word.
REQ-007 SHALL have port ld_last  input  1  marks final program byte, qualified by ld_valid.
REQ-008 SHALL have port ld_ready  output  1  byte accepted when ld_valid and ld_ready are both high.
REQ-009 SHALL have port cpu_pc  input  8  processor fetch byte address.
REQ-010 SHALL have port mem_addr  output  8  byte address to instruction memory.
REQ-011 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-012 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-013 SHALL have port cpu_rst_n  output  1  processor reset, low while not RUN.
REQ-014 SHALL have port word_cnt  output  7  words written in current load.
REQ-015 SHALL have port err  output  1  load failure flag.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WRITE, CHECK, RUN, ERR.
REQ-017 SHALL go IDLE->LOAD on boot_start, clearing word_cnt, byte counter and assembly register.
REQ-018 SHALL assert ld_ready only in LOAD (and CHECK when compiled in).
REQ-019 SHALL place byte k (0..3) of a word into mem_wdata bits [8k+7:8k].
REQ-020 SHALL enter WRITE the cycle after the 4th byte of a word or any byte with ld_last is accepted.
REQ-021 SHALL in WRITE drive mem_we=1 for exactly one cycle, mem_addr=word_cnt*4, unfilled bytes zero.
REQ-022 SHALL increment word_cnt at end of WRITE; then go CHECK if last seen and macro defined, RUN if last seen, else LOAD.
REQ-023 SHALL go to ERR if a byte is accepted while word_cnt == WORDS (overflow); no write issued.
REQ-024 SHALL drive mem_addr=cpu_pc and mem_we=0 in RUN; mem_addr=word_cnt*4 otherwise.
REQ-025 SHALL hold cpu_rst_n=0 in every state except RUN; cpu_rst_n=1 from first RUN cycle.
REQ-026 SHALL on boot_start in RUN or ERR restart at LOAD next cycle (cpu_rst_n=0 that cycle).
REQ-027 SHALL ignore boot_start in LOAD, WRITE, CHECK.
REQ-028 SHALL hold err=1 only in ERR; cleared on leaving ERR.
REQ-029 SHALL treat ld_last accepted with ld_valid on a word boundary (byte 3) as a normal full-word write.

Reset
REQ-030 SHALL on rst_n=0 at a clock edge enter IDLE, regardless of state, including mid-load or mid-WRITE.
REQ-031 SHALL reset outputs: ld_ready=0, mem_we=0, mem_wdata=0, mem_addr=0, cpu_rst_n=0, word_cnt=0, err=0.
REQ-032 SHALL abandon a partially assembled word on reset; no write issued.

Configuration
REQ-033 SHALL, with IMEM_LOAD_CHECKSUM_EN defined, expect one extra byte in CHECK after the last write: RUN if it equals 8-bit sum mod 256 of all program bytes (padding excluded), else ERR.
REQ-034 SHALL, without IMEM_LOAD_CHECKSUM_EN, omit CHECK and the sum register; last write goes directly to RUN.

Verification
REQ-035 SHALL test: boot_start, bytes 13,03,A0,00 with ld_last on 4th -> one mem_we, addr 0, wdata 00A00313, RUN, cpu_rst_n=1.
REQ-036 SHALL test: 6 bytes 01..06, last on 6th -> writes 04030201 at 0 and 00000605 at 4, word_cnt=2.
REQ-037 SHALL test: WORDS=2, 9 bytes streamed -> 2 writes then ERR, err=1, cpu_rst_n=0; boot_start -> LOAD.
REQ-038 SHALL test: rst_n low after 2 bytes -> IDLE, no mem_we, all outputs at reset values.
REQ-039 SHALL test: in RUN, cpu_pc=24 -> mem_addr=24, mem_we=0; boot_start -> cpu_rst_n=0 next cycle.
REQ-040 SHALL test (macro on): bytes 01,02,03,04 then checksum 0A -> RUN; checksum 0B -> ERR.
